// File: rtl/btn_conditioner_if.sv
// Pushbutton conditioner bus: raw active-low buttons in, clean levels, edge strobes
// and the last-pressed key code out.
interface btn_conditioner_if #(
  parameter int N_BTN      = 4,
  parameter int CODE_WIDTH = 2
);
  logic [N_BTN-1:0]      btn_n;
  logic [N_BTN-1:0]      btn_level;
  logic [N_BTN-1:0]      btn_press;
  logic [N_BTN-1:0]      btn_release;
  logic                  key_valid;
  logic [CODE_WIDTH-1:0] key_code;

  modport master (
    output btn_n,
    input  btn_level, btn_press, btn_release, key_valid, key_code
  );

  modport slave (
    input  btn_n,
    output btn_level, btn_press, btn_release, key_valid, key_code
  );
endinterface

// File: rtl/btn_conditioner.sv
// Per-button 2-FF synchronizer, counter debouncer and press/release strobes,
// plus a lowest-index key encoder latching the last pressed button.
module btn_conditioner #(
  parameter int N_BTN           = 4,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_WIDTH       = 19,
  parameter int CODE_WIDTH      = 2
) (
  input  logic             clk,
  input  logic             rst,
  btn_conditioner_if.slave bus
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ZERO = {CNT_WIDTH{1'b0}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

  logic [N_BTN-1:0]      s1_q, s1_d;
  logic [N_BTN-1:0]      s2_q, s2_d;
  logic [N_BTN-1:0]      stable_q, stable_d;
  logic [N_BTN-1:0]      press_q, press_d;
  logic [N_BTN-1:0]      release_q, release_d;
  logic                  key_valid_q, key_valid_d;
  logic [CODE_WIDTH-1:0] key_code_q, key_code_d;
  logic [CNT_WIDTH-1:0]  cnt_q [N_BTN];
  logic [CNT_WIDTH-1:0]  cnt_d [N_BTN];
  logic [N_BTN-1:0]      sync;
  logic [N_BTN-1:0]      flip;

  // Next-state: synchronizer shift, debounce counters, edge strobes, key encoder
  always_comb begin
    s1_d  = bus.btn_n;
    s2_d  = s1_q;
    sync  = ~s2_q;
    flip  = {N_BTN{1'b0}};
    cnt_d = cnt_q;
    for (int i = 0; i < N_BTN; i++) begin
      if (sync[i] == stable_q[i]) begin
        cnt_d[i] = CNT_ZERO;
      end else if (cnt_q[i] == CNT_MAX) begin
        cnt_d[i] = CNT_ZERO;
        flip[i]  = 1'b1;
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_ONE;
      end
    end
    stable_d    = stable_q ^ flip;
    press_d     = flip & ~stable_q;
    release_d   = flip & stable_q;
    key_valid_d = |press_d;
    key_code_d  = key_code_q;
    // Descending scan so the lowest pressed index is the one that sticks
    for (int i = N_BTN - 1; i >= 0; i--) begin
      if (press_d[i]) begin
        key_code_d = CODE_WIDTH'(i);
      end else begin
        key_code_d = key_code_d;
      end
    end
  end

  // State registers; synchronizer resets to released so no spurious press follows reset
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q        <= {N_BTN{1'b1}};
      s2_q        <= {N_BTN{1'b1}};
      stable_q    <= {N_BTN{1'b0}};
      press_q     <= {N_BTN{1'b0}};
      release_q   <= {N_BTN{1'b0}};
      key_valid_q <= 1'b0;
      key_code_q  <= {CODE_WIDTH{1'b0}};
      for (int i = 0; i < N_BTN; i++) begin
        cnt_q[i] <= CNT_ZERO;
      end
    end else begin
      s1_q        <= s1_d;
      s2_q        <= s2_d;
      stable_q    <= stable_d;
      press_q     <= press_d;
      release_q   <= release_d;
      key_valid_q <= key_valid_d;
      key_code_q  <= key_code_d;
      for (int i = 0; i < N_BTN; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign bus.btn_level   = stable_q;
  assign bus.btn_press   = press_q;
  assign bus.btn_release = release_q;
  assign bus.key_valid   = key_valid_q;
  assign bus.key_code    = key_code_q;

endmodule
